// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg -- shared definitions for the two-master Wishbone arbiter.
//   arb_state_e   : arbiter FSM states. The grant states are encoded one-hot
//                   ({m1,m0}) so the state register doubles as the grant.
//   TIMEOUT_CNT_W : width of the optional stall-timeout counter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_e;

  localparam int TIMEOUT_CNT_W = 16;

endpackage

// File: rtl/wb_arb_timeout.sv
// wb_arb_timeout -- stall watchdog for the granted bus cycle.
// Built only when WB_ARBITER_TIMEOUT_EN is defined.
// Counts cycles in which the slave strobe is high without ACK/ERR.
// The count restarts on any grant change, ACK or ERR. timeout_o is high
// for the single cycle in which the count equals TIMEOUT.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   gnt_i      : current one-hot grant
//   stb_i      : slave strobe as driven by the arbiter
//   ack_i      : slave acknowledge
//   err_i      : slave error
//   timeout_o  : one-cycle timeout pulse
module wb_arb_timeout
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] gnt_i,
  input  logic       stb_i,
  input  logic       ack_i,
  input  logic       err_i,
  output logic       timeout_o
);

  localparam logic [TIMEOUT_CNT_W-1:0] LIMIT = TIMEOUT_CNT_W'(TIMEOUT);

  logic [TIMEOUT_CNT_W-1:0] cnt;
  logic [1:0]               gnt_q;

  assign timeout_o = (cnt == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      gnt_q <= '0;
    end else begin
      gnt_q <= gnt_i;
      if (ack_i || err_i || timeout_o) begin
        cnt <= '0;
      end else if (gnt_i != gnt_q) begin
        // The first cycle of a new grant already counts, so that the pulse
        // lands exactly TIMEOUT cycles after the strobe first appears.
        cnt <= TIMEOUT_CNT_W'(stb_i);
      end else if (stb_i) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m -- two-master / one-slave classic Wishbone arbiter.
// Grants whole CYC-framed bus cycles round-robin. The grant is registered;
// slave-side signals are muxed combinationally from the granted master.
// Optional macro WB_ARBITER_TIMEOUT_EN adds a stall watchdog that pulses
// the granted master's err after TIMEOUT strobe cycles without ACK/ERR.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   m0_* / m1_*           : master-side Wishbone (cyc/stb/we/adr/dat/sel in,
//                           dat/ack/err out)
//   s_*                   : slave-side Wishbone
//   gnt_o                 : one-hot grant {m1,m0}, 2'b00 when idle
module wb_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 30,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8
`ifdef WB_ARBITER_TIMEOUT_EN
  ,
  parameter int TIMEOUT    = 255
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  input  logic [SEL_WIDTH-1:0]  m0_sel_i,
  output logic [DATA_WIDTH-1:0] m0_dat_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  input  logic [SEL_WIDTH-1:0]  m1_sel_i,
  output logic [DATA_WIDTH-1:0] m1_dat_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  output logic [SEL_WIDTH-1:0]  s_sel_o,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,
  output logic [1:0]            gnt_o
);

  arb_state_e state;
  logic       ptr;  // round-robin priority: 0 favours m0, 1 favours m1

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
      ptr   <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (m0_cyc_i && m1_cyc_i) state <= ptr ? ARB_GNT1 : ARB_GNT0;
          else if (m0_cyc_i)        state <= ARB_GNT0;
          else if (m1_cyc_i)        state <= ARB_GNT1;
        end
        // A grant is held for the whole CYC frame; on release the pointer
        // moves to the other master so it wins the next contention.
        ARB_GNT0: begin
          if (!m0_cyc_i) begin
            ptr   <= 1'b1;
            state <= m1_cyc_i ? ARB_GNT1 : ARB_IDLE;
          end
        end
        ARB_GNT1: begin
          if (!m1_cyc_i) begin
            ptr   <= 1'b0;
            state <= m0_cyc_i ? ARB_GNT0 : ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Grant states are one-hot encoded, so the grant is the state register.
  assign gnt_o = state;

  // NOTE: every output gets a default before the branches, so no path
  // through this block leaves a value unassigned (no latches).
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    if (gnt_o[0]) begin
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
      s_we_o  = m0_we_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
    end else if (gnt_o[1]) begin
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
      s_we_o  = m1_we_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
    end
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  // A late ACK after the grant has moved goes to the new owner.
  assign m0_ack_o = gnt_o[0] & s_ack_i;
  assign m1_ack_o = gnt_o[1] & s_ack_i;

`ifdef WB_ARBITER_TIMEOUT_EN
  logic timeout;

  wb_arb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .gnt_i     (gnt_o),
    .stb_i     (s_stb_o),
    .ack_i     (s_ack_i),
    .err_i     (s_err_i),
    .timeout_o (timeout)
  );

  assign m0_err_o = gnt_o[0] & (s_err_i | timeout);
  assign m1_err_o = gnt_o[1] & (s_err_i | timeout);
`else
  assign m0_err_o = gnt_o[0] & s_err_i;
  assign m1_err_o = gnt_o[1] & s_err_i;
`endif

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb_wb_arbiter_2m -- self-checking bench for wb_arbiter_2m.
// A small behavioural RAM slave answers on the slave port (registered ACK).
// An owner/pointer reference model predicts the grant every cycle, and a
// negedge monitor compares grant, slave mux and ack/err/data routing.
// Directed scenarios are followed by a randomized phase.
// With WB_ARBITER_TIMEOUT_EN defined the DUT is built with TIMEOUT = 8.
module tb_wb_arbiter_2m;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc [2];
  logic        stb [2];
  logic        we  [2];
  logic [29:0] adr [2];
  logic [31:0] wdat[2];
  logic [3:0]  sel [2];

  logic [31:0] m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i;
  logic [29:0] s_adr_o;
  logic [3:0]  s_sel_o;
  logic [1:0]  gnt_o;

  logic        ram_ack, ram_en, err_inj;
  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter_2m #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (30)
`ifdef WB_ARBITER_TIMEOUT_EN
    ,
    .TIMEOUT    (8)
`endif
  ) dut (
    .clk      (clk),      .rst_n    (rst_n),
    .m0_cyc_i (cyc[0]),   .m0_stb_i (stb[0]),   .m0_we_i  (we[0]),
    .m0_adr_i (adr[0]),   .m0_dat_i (wdat[0]),  .m0_sel_i (sel[0]),
    .m0_dat_o (m0_dat_o), .m0_ack_o (m0_ack_o), .m0_err_o (m0_err_o),
    .m1_cyc_i (cyc[1]),   .m1_stb_i (stb[1]),   .m1_we_i  (we[1]),
    .m1_adr_i (adr[1]),   .m1_dat_i (wdat[1]),  .m1_sel_i (sel[1]),
    .m1_dat_o (m1_dat_o), .m1_ack_o (m1_ack_o), .m1_err_o (m1_err_o),
    .s_cyc_o  (s_cyc_o),  .s_stb_o  (s_stb_o),  .s_we_o   (s_we_o),
    .s_adr_o  (s_adr_o),  .s_dat_o  (s_dat_o),  .s_sel_o  (s_sel_o),
    .s_dat_i  (s_dat_i),  .s_ack_i  (s_ack_i),  .s_err_i  (s_err_i),
    .gnt_o    (gnt_o)
  );

  // ---------------- behavioural RAM slave ----------------
  assign s_dat_i = mem[s_adr_o[7:0]];
  assign s_ack_i = ram_ack;
  assign s_err_i = err_inj & s_cyc_o & s_stb_o;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_ack  <= 1'b0;
      mem[16]  <= 32'hDEADBEEF;
    end else if (ram_en && s_cyc_o && s_stb_o && !ram_ack) begin
      ram_ack <= 1'b1;
      if (s_we_o)
        for (int b = 0; b < 4; b++)
          if (s_sel_o[b]) mem[s_adr_o[7:0]][8*b +: 8] <= s_dat_o[8*b +: 8];
    end else begin
      ram_ack <= 1'b0;
    end
  end

  // ---------------- reference model ----------------
  // owner: -1 when nobody holds the bus, else the master index.
  // favoured: which master wins when both ask while the bus is free.
  int owner    = -1;
  int favoured = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner    = -1;
      favoured = 0;
    end else if (owner < 0) begin
      if (cyc[0] && cyc[1]) owner = favoured;
      else if (cyc[0])      owner = 0;
      else if (cyc[1])      owner = 1;
    end else if (!cyc[owner]) begin
      favoured = 1 - owner;
      owner    = cyc[favoured] ? favoured : -1;
    end
  end

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- per-cycle monitor ----------------
  logic [1:0]  exp_gnt;
  logic [68:0] exp_bus;

  always @(negedge clk) begin
    if (rst_n) begin
      if (owner < 0) begin
        exp_gnt = 2'b00;
        exp_bus = '0;
      end else begin
        exp_gnt = (owner == 0) ? 2'b01 : 2'b10;
        exp_bus = {cyc[owner], stb[owner], we[owner], adr[owner], wdat[owner], sel[owner]};
      end
      check("mon_gnt", gnt_o, exp_gnt);
      check("mon_slave_bus", {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o}, exp_bus);
      check("mon_ack", {m1_ack_o, m0_ack_o}, {owner == 1 && s_ack_i, owner == 0 && s_ack_i});
`ifndef WB_ARBITER_TIMEOUT_EN
      check("mon_err", {m1_err_o, m0_err_o}, {owner == 1 && s_err_i, owner == 0 && s_err_i});
`endif
      check("mon_rdata", {m1_dat_o, m0_dat_o}, {s_dat_i, s_dat_i});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // One classic transfer for master m; leaves CYC asserted, drops STB.
  task automatic xfer(input int m, input logic w, input logic [29:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd);
    logic got;
    cyc[m] = 1'b1; stb[m] = 1'b1; we[m] = w;
    adr[m] = a;    wdat[m] = d;   sel[m] = s;
    rd  = 'x;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if ((m == 0) ? m0_ack_o : m1_ack_o) begin
        got = 1'b1;
        rd  = (m == 0) ? m0_dat_o : m1_dat_o;
      end
    end
    check("xfer_ack_seen", got, 1'b1);
    next();
    stb[m] = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  logic [31:0] rd;
  int          ow, first_err, err_cycles;

  initial begin
    rst_n = 1'b0; ram_en = 1'b1; err_inj = 1'b0;
    for (int m = 0; m < 2; m++) begin
      cyc[m] = 0; stb[m] = 0; we[m] = 0; adr[m] = '0; wdat[m] = '0; sel[m] = '0;
    end

    // reset state
    repeat (2) @(posedge clk);
    #2;
    check("rst_gnt", gnt_o, 2'b00);
    check("rst_slave", {s_cyc_o, s_stb_o}, 2'b00);
    check("rst_ack_err", {m1_ack_o, m0_ack_o, m1_err_o, m0_err_o}, 4'b0000);
    next();
    rst_n = 1'b1;
    next();

    // 1: m0 alone reads 0x10, one-cycle grant latency
    cyc[0] = 1; stb[0] = 1; we[0] = 0; adr[0] = 30'h10; sel[0] = 4'hF;
    @(negedge clk);
    check("t1_gnt_latency0", gnt_o, 2'b00);
    @(negedge clk);
    check("t1_gnt_m0", gnt_o, 2'b01);
    xfer(0, 1'b0, 30'h10, 32'h0, 4'hF, rd);
    check("t1_rdata", rd, 32'hDEADBEEF);
    cyc[0] = 0;
    next();

    // 2: both request after reset -> m0 first, then m1 reads back
    rst_n = 1'b0;
    next();
    rst_n = 1'b1;
    next();
    cyc[0] = 1; cyc[1] = 1; stb[1] = 1; adr[1] = 30'h20; sel[1] = 4'hF;
    xfer(0, 1'b1, 30'h20, 32'h11223344, 4'hF, rd);
    check("t2_gnt_m0_held", gnt_o, 2'b01);
    cyc[0] = 0;
    @(negedge clk);
    check("t2_release_cyc_low", {gnt_o, s_cyc_o, s_stb_o}, {2'b01, 2'b00});
    next();
    check("t2_gnt_m1", gnt_o, 2'b10);
    xfer(1, 1'b0, 30'h20, 32'h0, 4'hF, rd);
    check("t2_readback", rd, 32'h11223344);
    cyc[1] = 0;
    next();

    // 3: both request continuously -> grants alternate
    cyc[0] = 1; cyc[1] = 1;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 10 && gnt_o == 2'b00; i++) next();
      check("t3_alternate", gnt_o, (k % 2 == 0) ? 2'b01 : 2'b10);
      ow = (gnt_o == 2'b10) ? 1 : 0;
      repeat (3) next();
      cyc[ow] = 0;
      next();
      cyc[ow] = 1;
    end
    cyc[0] = 0; cyc[1] = 0;
    repeat (2) next();

    // 4: m0 holds CYC across byte-lane writes while m1 waits
    cyc[0] = 1;
    next();
    cyc[1] = 1;
    xfer(0, 1'b1, 30'h30, 32'hAABBCCDD, 4'b0011, rd);
    xfer(0, 1'b1, 30'h30, 32'h55667788, 4'b1100, rd);
    xfer(0, 1'b0, 30'h30, 32'h0,        4'b1111, rd);
    check("t4_merged", rd, 32'h5566CCDD);
    xfer(0, 1'b1, 30'h30, 32'h0F0F0F0F, 4'b1111, rd);
    check("t4_m0_still_owner", gnt_o, 2'b01);
    cyc[0] = 0;
    next();
    check("t4_gnt_m1", gnt_o, 2'b10);
    xfer(1, 1'b0, 30'h30, 32'h0, 4'hF, rd);
    check("t4_full_write", rd, 32'h0F0F0F0F);
    cyc[1] = 0;
    repeat (2) next();

    // 5: async reset during GNT1 with STB high; pointer returns to m0
    xfer(0, 1'b0, 30'h10, 32'h0, 4'hF, rd);
    cyc[0] = 0;
    next();
    ram_en = 0;
    cyc[1] = 1; stb[1] = 1;
    next();
    check("t5_gnt_m1", gnt_o, 2'b10);
    next();
    #3 rst_n = 1'b0;
    #1;
    check("t5_async_gnt", gnt_o, 2'b00);
    check("t5_async_slave", {s_cyc_o, s_stb_o, m1_ack_o, m1_err_o}, 4'b0000);
    cyc[1] = 0; stb[1] = 0; ram_en = 1;
    next();
    rst_n = 1'b1;
    cyc[0] = 1; cyc[1] = 1;
    next();
    check("t5_ptr_reset_m0", gnt_o, 2'b01);
    cyc[0] = 0; cyc[1] = 0;
    repeat (2) next();

    // 6: slave never acknowledges
    ram_en = 0;
    cyc[0] = 1; stb[0] = 1; we[0] = 0; adr[0] = 30'h10;
    for (int i = 0; i < 10 && !s_stb_o; i++) @(negedge clk);
    check("t6_stb_up", s_stb_o, 1'b1);
    first_err  = -1;
    err_cycles = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (m0_err_o) begin
        err_cycles++;
        if (first_err < 0) first_err = k;
      end
    end
`ifdef WB_ARBITER_TIMEOUT_EN
    check("t6_timeout_at_8", first_err, 8);
    check("t6_single_pulse", err_cycles, 1);
`else
    check("t6_no_err", err_cycles, 0);
    check("t6_stalled", {s_stb_o, m0_ack_o}, 2'b10);
`endif
    next();
    cyc[0] = 0; stb[0] = 0; ram_en = 1;
    repeat (2) next();

    // 7: randomized traffic, monitor compares every cycle
    for (int n = 0; n < 400; n++) begin
      for (int m = 0; m < 2; m++) begin
        if ($urandom_range(3) == 0) cyc[m] = ~cyc[m];
        stb[m]  = cyc[m] & 1'($urandom_range(1));
        we[m]   = 1'($urandom_range(1));
        adr[m]  = 30'($urandom_range(255));
        wdat[m] = $urandom;
        sel[m]  = 4'($urandom_range(15));
      end
      err_inj = ($urandom_range(7) == 0);
      next();
    end
    cyc[0] = 0; cyc[1] = 0; stb[0] = 0; stb[1] = 0; err_inj = 0;
    repeat (3) next();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
